fetch_hazard_controller: RTL and testbench

- Sequences the fetch stage and the fetch/decode pipeline register.
- Generates StallF, StallD, FlushD and FlushE from three sources:
  - branch redirect (PCSrcE);
  - load-use hazards between the execute and decode stages;
  - a multi-cycle instruction-memory request/ready handshake.
- Also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
- Sits beside the fetch stage. It drives the PC enable, the IF/ID register enable/clear, and the ID/EX register clear.

---
 rtl/fetch_hazard_controller.sv | 104 ++++++++++
 tb/tb_fetch_hazard_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_hazard_controller.sv
// Fetch-stage sequencer: turns branch redirects, load-use hazards and a slow
// instruction-memory handshake into PC / IF-ID / ID-EX stall and flush controls.
module fetch_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrcE,
  input  logic                  MemReadE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic                  imem_ready,
  output logic                  imem_req,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  imem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_EDGE  = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0]  stall_count_reg;
  logic              timeout_reg;
  logic              lu;

  assign lu = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Redirect always beats load-use: a stalled decode instruction would be wrong-path.
  always_comb begin
    imem_req = 1'b0;
    StallF   = 1'b1;
    StallD   = 1'b0;
    FlushD   = 1'b1;
    FlushE   = 1'b1;
    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (PCSrcE) begin
          StallF = 1'b0; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b1;
        end else if (lu) begin
          StallF = 1'b1; StallD = 1'b1; FlushD = 1'b0; FlushE = 1'b1;
        end else if (!imem_ready) begin
          StallF = 1'b1; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b0;
        end else begin
          StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        end
      end
      DROP: begin
        imem_req = 1'b1;
        if (PCSrcE) begin
          StallF = 1'b0; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b1;
        end else if (lu) begin
          StallF = 1'b1; StallD = 1'b1; FlushD = 1'b0; FlushE = 1'b1;
        end else begin
          StallF = 1'b1; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      stall_count_reg <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:    state_reg <= FETCH;
        FETCH:   if (PCSrcE && !imem_ready) state_reg <= DROP;
        DROP:    if (imem_ready) state_reg <= FETCH;
        default: state_reg <= IDLE;
      endcase

      if (state_reg == IDLE || imem_ready)
        wait_cnt_reg <= '0;
      else if (wait_cnt_reg != WAIT_LIMIT)
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);

      // Flag on the edge that completes the MAX_WAIT-th consecutive miss.
      if (state_reg != IDLE && !imem_ready && wait_cnt_reg >= WAIT_EDGE)
        timeout_reg <= 1'b1;

      if (StallF && stall_count_reg != '1)
        stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign stall_count  = stall_count_reg;
  assign imem_timeout = timeout_reg;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed and randomized bench for fetch_hazard_controller with a rule-level model.
module tb_fetch_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       PCSrcE, MemReadE, imem_ready;
  logic [4:0] RdE, Rs1D, Rs2D;
  logic       imem_req, StallF, StallD, FlushD, FlushE, imem_timeout;
  logic [15:0] stall_count;
  logic       s_req, s_sf, s_sd, s_fd, s_fe, s_timeout;
  logic [3:0] small_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_hazard_controller dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .MemReadE(MemReadE), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .imem_ready(imem_ready), .imem_req(imem_req),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stall_count(stall_count), .imem_timeout(imem_timeout)
  );

  fetch_hazard_controller #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .MemReadE(MemReadE), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .imem_ready(imem_ready), .imem_req(s_req),
    .StallF(s_sf), .StallD(s_sd), .FlushD(s_fd), .FlushE(s_fe),
    .stall_count(small_count), .imem_timeout(s_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model state: "fresh" = first cycle out of reset, "discard" = stale request outstanding.
  bit fresh = 1'b1;
  bit discard = 1'b0;
  int miss_run = 0;
  bit timeout_m = 1'b0;
  int stalls = 0;

  // {imem_req, StallF, StallD, FlushD, FlushE} derived from the hazard rules.
  function automatic logic [4:0] model_outs();
    logic l;
    l = MemReadE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    if (fresh) return 5'b01011;
    return {1'b1,
            !PCSrcE && (discard || l || !imem_ready),
            !PCSrcE && l,
            PCSrcE || (!l && (discard || !imem_ready)),
            PCSrcE || l};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fresh <= 1'b1; discard <= 1'b0; miss_run <= 0; timeout_m <= 1'b0; stalls <= 0;
    end else begin
      if (model_outs() & 5'b01000) stalls <= (stalls < 65535) ? stalls + 1 : stalls;
      fresh <= 1'b0;
      if (fresh) begin
        miss_run <= 0;
        discard  <= 1'b0;
      end else begin
        if (!imem_ready) begin
          miss_run <= (miss_run < 15) ? miss_run + 1 : 15;
          if (miss_run + 1 >= 15) timeout_m <= 1'b1;
        end else begin
          miss_run <= 0;
        end
        discard <= !imem_ready && (discard || PCSrcE);
      end
    end
  end

  always @(negedge clk) begin
    check("outs", 32'({imem_req, StallF, StallD, FlushD, FlushE}), 32'(model_outs()));
    check("small_outs", 32'({s_req, s_sf, s_sd, s_fd, s_fe}), 32'(model_outs()));
    check("stall_count", 32'(stall_count), 32'(stalls));
    check("small_count", 32'(small_count), 32'((stalls > 15) ? 15 : stalls));
    check("timeout", 32'(imem_timeout), 32'(timeout_m));
    check("small_timeout", 32'(s_timeout), 32'(timeout_m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [4:0] exp);
    #1;
    check(name, 32'({imem_req, StallF, StallD, FlushD, FlushE}), 32'(exp));
    $display("step %s outs=%b", name, {imem_req, StallF, StallD, FlushD, FlushE});
  endtask

  int sc0;
  int burst;

  initial begin
    rst = 1'b0; PCSrcE = 0; MemReadE = 0; RdE = 0; Rs1D = 0; Rs2D = 0; imem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset_idle", 5'b01011);
    check("reset_count", 32'(stall_count), 0);
    rst = 1'b1;
    chk_outs("first_after_release", 5'b01011);
    tick();
    chk_outs("fetch_run", 5'b10000);
    check("count_after_start", 32'(stall_count), 1);

    MemReadE = 1; RdE = 5; Rs1D = 5;
    chk_outs("load_use", 5'b11101);
    tick();
    RdE = 0;
    chk_outs("load_use_r0", 5'b10000);
    tick();
    MemReadE = 0; Rs1D = 0;

    sc0 = int'(stall_count);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 0;
      chk_outs("fetch_miss", 5'b11010);
      tick();
    end
    imem_ready = 1;
    chk_outs("miss_clear", 5'b10000);
    check("miss_count", 32'(stall_count), 32'(sc0 + 4));
    check("miss_no_timeout", 32'(imem_timeout), 0);
    tick();

    imem_ready = 0; PCSrcE = 1;
    chk_outs("redirect_miss", 5'b10011);
    tick();
    PCSrcE = 0;
    for (int i = 0; i < 2; i++) begin
      chk_outs("drop", 5'b11010);
      tick();
    end
    imem_ready = 1;
    chk_outs("drop_ready", 5'b11010);
    tick();
    chk_outs("back_to_fetch", 5'b10000);
    tick();

    PCSrcE = 1; MemReadE = 1; RdE = 5; Rs2D = 5;
    chk_outs("redirect_vs_lu", 5'b10011);
    tick();
    PCSrcE = 0; MemReadE = 0; RdE = 0; Rs2D = 0;
    tick();

    for (int i = 1; i <= 20; i++) begin
      imem_ready = 0;
      tick();
      check("timeout_run", 32'(imem_timeout), 32'(i >= 15));
    end
    imem_ready = 1;
    repeat (3) tick();
    check("timeout_sticky", 32'(imem_timeout), 1);
    check("small_saturated", 32'(small_count), 15);
    $display("step directed done total=%0d", total);

    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if (burst > 0) begin
        imem_ready = 0;
        burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        burst = int'($urandom_range(1, 25));
        imem_ready = 0;
      end else begin
        imem_ready = ($urandom_range(0, 3) != 0);
      end
      PCSrcE   = ($urandom_range(0, 5) == 0);
      MemReadE = ($urandom_range(0, 2) == 0);
      RdE  = 5'($urandom_range(0, 3));
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        #3 rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
      end
      tick();
    end
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
